// File: rtl/ones_gen_pkg.sv
// ones_gen_pkg: shared FSM encoding and constants for ones_pattern_gen.
// Also carries the LFSR seed, tap mask and step function.
package ones_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIV   = 10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1, right-shifting form: taps on bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/ones_pattern_gen_tick_div.sv
// tick_div: free-running 0..DIV-1 counter with synchronous clear.
// tick is high during the last count while enabled.
module tick_div
    import ones_gen_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: serially builds a WIDTH-bit word with exactly ones_req 1s.
// Define PATTERN_SCRAMBLE_EN to spread the ones with a 16-bit LFSR.
module ones_pattern_gen
    import ones_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int DIV   = DEF_DIV
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    ones_req,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] pattern_out,
    output logic             serial_bit,
    output logic             serial_valid
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    ones_left, ones_nxt;
    logic [CW-1:0]    slots_left, slots_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [WIDTH-1:0] pat_nxt;
    logic [IW-1:0]    idx;
    logic             clr, tick, emit, err_nxt;
    logic             bit_b, free_bit;

    tick_div #(.DIV(DIV)) u_div (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (clr),
        .en     (state == SHIFT),
        .tick   (tick)
    );

`ifdef PATTERN_SCRAMBLE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (emit) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign free_bit = lfsr[0];
`else
    assign free_bit = 1'b1;
`endif

    assign idx = IW'(WIDTH - int'(slots_left));

    // Forced zeros/ones first keep popcount exact regardless of free_bit
    always_comb begin
        if (ones_left == '0) begin
            bit_b = 1'b0;
        end else if (ones_left == slots_left) begin
            bit_b = 1'b1;
        end else begin
            bit_b = free_bit;
        end
    end

    always_comb begin
        state_nxt = state;
        ones_nxt  = ones_left;
        slots_nxt = slots_left;
        sh_nxt    = sh;
        pat_nxt   = pattern_out;
        clr       = 1'b0;
        emit      = 1'b0;
        err_nxt   = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (start) begin
                    if (ones_req > CW'(WIDTH)) begin
                        err_nxt = 1'b1;
                    end else begin
                        ones_nxt  = ones_req;
                        slots_nxt = CW'(WIDTH);
                        sh_nxt    = '0;
                        clr       = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
            end
            (state == SHIFT): begin
                if (tick) begin
                    emit        = 1'b1;
                    sh_nxt[idx] = bit_b;
                    slots_nxt   = slots_left - CW'(1);
                    if (bit_b) begin
                        ones_nxt = ones_left - CW'(1);
                    end
                    if (slots_left == CW'(1)) begin
                        pat_nxt   = sh_nxt;
                        state_nxt = DONE;
                    end
                end
            end
            (state == DONE): begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ones_left    <= '0;
            slots_left   <= '0;
            sh           <= '0;
            pattern_out  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            serial_bit   <= 1'b0;
            serial_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            ones_left    <= ones_nxt;
            slots_left   <= slots_nxt;
            sh           <= sh_nxt;
            pattern_out  <= pat_nxt;
            busy         <= (state_nxt != IDLE);
            done         <= (state_nxt == DONE);
            err          <= err_nxt;
            serial_bit   <= emit & bit_b;
            serial_valid <= emit;
        end
    end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: directed checks of ones_pattern_gen (WIDTH=32, DIV=10).
// Covers reset, extremes, err path, mid-run reset and ignored restart.
module tb_ones_pattern_gen;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  ones_req;
    logic        busy, done, err, serial_bit, serial_valid;
    logic [31:0] pattern_out;

    int checks   = 0;
    int failures = 0;

    int          n_strobe, first_s, last_s, bad_pos;
    int          n_done, done_at, busy_last, n_err;
    logic [31:0] sbits;

    ones_pattern_gen #(
        .WIDTH (32),
        .CW    (6),
        .DIV   (10)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .start        (start),
        .ones_req     (ones_req),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .pattern_out  (pattern_out),
        .serial_bit   (serial_bit),
        .serial_valid (serial_valid)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic int pop(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // start is high across exactly one edge (E0); returns at E0's negedge
    task automatic kick(input logic [5:0] req);
        @(negedge clk_in);
        start    = 1'b1;
        ones_req = req;
        @(negedge clk_in);
        start    = 1'b0;
    endtask

    // Samples after edges E0+1..E0+cycles; inj raises start for edge inj+1
    task automatic watch(input int cycles, input int inj);
        n_strobe  = 0;
        first_s   = 0;
        last_s    = 0;
        bad_pos   = 0;
        n_done    = 0;
        done_at   = 0;
        busy_last = 0;
        n_err     = 0;
        sbits     = '0;
        for (int n = 1; n <= cycles; n++) begin
            @(negedge clk_in);
            if (serial_valid) begin
                if (n_strobe < 32) sbits[n_strobe] = serial_bit;
                n_strobe++;
                if (n % 10 != 0) bad_pos++;
                if (first_s == 0) first_s = n;
                last_s = n;
            end
            if (done) begin
                n_done++;
                done_at = n;
            end
            if (busy) busy_last = n;
            if (err) n_err++;
            if (n == inj) begin
                start    = 1'b1;
                ones_req = 6'd1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic run_full(input string tag, input logic [5:0] req,
                            input logic [31:0] exp, input int inj);
        kick(req);
        chk({tag, " busy_e0"}, busy, 1);
        watch(330, inj);
        chk({tag, " strobes"}, n_strobe, 32);
        chk({tag, " first_strobe"}, first_s, 10);
        chk({tag, " last_strobe"}, last_s, 320);
        chk({tag, " strobe_pos"}, bad_pos, 0);
        chk({tag, " done_cnt"}, n_done, 1);
        chk({tag, " done_at"}, done_at, 320);
        chk({tag, " busy_last"}, busy_last, 320);
        chk({tag, " err_cnt"}, n_err, 0);
`ifdef PATTERN_SCRAMBLE_EN
        chk({tag, " serial_pop"}, pop(sbits), pop(exp));
        chk({tag, " pattern_pop"}, pop(pattern_out), pop(exp));
`else
        chk({tag, " serial_bits"}, sbits, exp);
        chk({tag, " pattern"}, pattern_out, exp);
`endif
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        ones_req = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst sval", serial_valid, 0);
        chk("rst sbit", serial_bit, 0);
        chk("rst pattern", pattern_out, 0);
        reset = 1'b1;

        run_full("zeros", 6'd0, 32'h0000_0000, -1);
        run_full("ones", 6'd32, 32'hFFFF_FFFF, -1);

        kick(6'd33);
        chk("ovf err", err, 1);
        chk("ovf busy", busy, 0);
        @(negedge clk_in);
        chk("ovf err_pulse", err, 0);
        watch(30, -1);
        chk("ovf done", n_done, 0);
        chk("ovf busy_any", busy_last, 0);
        chk("ovf pattern", pattern_out, 32'hFFFF_FFFF);

        run_full("five", 6'd5, 32'h0000_001F, -1);

        kick(6'd7);
        watch(99, -1);
        chk("abort pre_done", n_done, 0);
        @(posedge clk_in);
        #1 reset = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort sval", serial_valid, 0);
        chk("abort pattern", pattern_out, 0);
        @(negedge clk_in);
        reset = 1'b1;
        watch(40, -1);
        chk("abort no_done", n_done, 0);
        chk("abort idle", busy_last, 0);
        run_full("rerun", 6'd3, 32'h0000_0007, -1);

        run_full("ignore", 6'd7, 32'h0000_007F, 49);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
